instr_seq_ctrl: RTL

- Opcode-aware control sequencer for the accumulator datapath (PC, IR, ACC, ALU, single memory port).
- Replaces the free-running strobe counter with a state machine. Strobes depend on the decoded opcode, stretch for memory wait states via mem_ready, and stop on HLT or an illegal opcode.
- Sits between the instruction register and the datapath load/enable inputs.

---
 rtl/instr_seq_ctrl.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/instr_seq_ctrl.sv
// Opcode-aware control sequencer: Moore strobes from registered state + latched opcode; NOP 3, JMP/JZ 4, others 5 cycles.
// Stalls in FETCH/MEM while mem_ready=0; optional MEM_TIMEOUT_EN bounds those waits and halts on expiry.
module instr_seq_ctrl #(
  parameter int OPC_W          = 4,
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [OPC_W-1:0] ir_opcode,
  input  logic             acc_zero,
  input  logic             mem_ready,
  output logic             mrd,
  output logic             mwr,
  output logic             ld_pc,
  output logic             inc_pc,
  output logic             ld_ir,
  output logic             ld_acc,
  output logic             alu_setup,
  output logic [2:0]       alu_op,
  output logic             busy,
  output logic             halted,
  output logic             illegal_op,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_LOAD_IR = 3'd2,
    S_DECODE  = 3'd3,
    S_EXEC    = 3'd4,
    S_MEM     = 3'd5,
    S_WB      = 3'd6,
    S_HALT    = 3'd7
  } state_t;

  localparam logic [OPC_W-1:0] OP_NOP = OPC_W'(4'h0);
  localparam logic [OPC_W-1:0] OP_LDA = OPC_W'(4'h1);
  localparam logic [OPC_W-1:0] OP_STA = OPC_W'(4'h2);
  localparam logic [OPC_W-1:0] OP_ADD = OPC_W'(4'h3);
  localparam logic [OPC_W-1:0] OP_XOR = OPC_W'(4'h7);
  localparam logic [OPC_W-1:0] OP_JMP = OPC_W'(4'h8);
  localparam logic [OPC_W-1:0] OP_JZ  = OPC_W'(4'h9);
  localparam logic [OPC_W-1:0] OP_HLT = OPC_W'(4'hF);

  state_t           r_state;
  state_t           w_next;
  logic [OPC_W-1:0] r_op;
  logic             r_illegal;
  logic [CNT_W-1:0] r_instr_count;
  logic             w_set_illegal;
  logic             w_count;
  logic             w_timeout;
  logic [OPC_W-1:0] w_alu_diff;
  logic             w_dec_alu;
  logic             w_op_alu;
  logic             w_in_wait;

  assign w_dec_alu  = (ir_opcode >= OP_ADD) && (ir_opcode <= OP_XOR);
  assign w_op_alu   = (r_op >= OP_ADD) && (r_op <= OP_XOR);
  assign w_alu_diff = r_op - OP_ADD;
  assign w_in_wait  = (r_state == S_FETCH) || (r_state == S_MEM);

`ifdef MEM_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_timeout;

  // The cycle that would bring the count to TIMEOUT_CYCLES is the last one allowed.
  assign w_timeout = w_in_wait && !mem_ready &&
                     (r_wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      if (w_in_wait && !mem_ready) r_wait_cnt <= r_wait_cnt + 1'b1;
      else                         r_wait_cnt <= '0;
      if (w_timeout) r_timeout <= 1'b1;
    end
  end

  assign mem_timeout = r_timeout;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (TIMEOUT_CYCLES == 0);
  assign w_timeout    = 1'b0;
  assign mem_timeout  = 1'b0;
`endif

  always_comb begin
    w_next        = r_state;
    w_set_illegal = 1'b0;
    case (r_state)
      S_IDLE:    if (start) w_next = S_FETCH;
      S_FETCH: begin
        if (mem_ready)      w_next = S_LOAD_IR;
        else if (w_timeout) w_next = S_HALT;
      end
      S_LOAD_IR: w_next = S_DECODE;
      S_DECODE: begin
        if (ir_opcode == OP_NOP)                             w_next = S_FETCH;
        else if (w_dec_alu)                                  w_next = S_EXEC;
        else if (ir_opcode == OP_LDA || ir_opcode == OP_STA) w_next = S_MEM;
        else if (ir_opcode == OP_JMP || ir_opcode == OP_JZ)  w_next = S_WB;
        else if (ir_opcode == OP_HLT)                        w_next = S_HALT;
        else begin
          w_next        = S_HALT;
          w_set_illegal = 1'b1;
        end
      end
      S_EXEC:    w_next = S_WB;
      S_MEM: begin
        if (mem_ready)      w_next = S_WB;
        else if (w_timeout) w_next = S_HALT;
      end
      S_WB:      w_next = S_FETCH;
      S_HALT:    w_next = S_HALT;
      default:   w_next = S_IDLE;
    endcase
  end

  assign w_count = (w_next == S_FETCH) && ((r_state == S_DECODE) || (r_state == S_WB));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_op          <= '0;
      r_illegal     <= 1'b0;
      r_instr_count <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_op <= ir_opcode;
      if (w_set_illegal)       r_illegal <= 1'b1;
      if (w_count)             r_instr_count <= r_instr_count + 1'b1;
    end
  end

  // Strobes see only registered state, so ir_opcode changes cannot reach them.
  always_comb begin
    mrd       = 1'b0;
    mwr       = 1'b0;
    ld_pc     = 1'b0;
    inc_pc    = 1'b0;
    ld_ir     = 1'b0;
    ld_acc    = 1'b0;
    alu_setup = 1'b0;
    alu_op    = 3'd0;
    case (r_state)
      S_FETCH:   mrd = 1'b1;
      S_LOAD_IR: begin
        ld_ir  = 1'b1;
        inc_pc = 1'b1;
      end
      S_EXEC: begin
        alu_setup = 1'b1;
        alu_op    = w_alu_diff[2:0];
      end
      S_MEM: begin
        mrd = (r_op == OP_LDA);
        mwr = (r_op == OP_STA);
      end
      S_WB: begin
        ld_acc = (r_op == OP_LDA) || w_op_alu;
        ld_pc  = (r_op == OP_JMP) || ((r_op == OP_JZ) && acc_zero);
      end
      default: ;
    endcase
  end

  assign busy        = (r_state != S_IDLE) && (r_state != S_HALT);
  assign halted      = (r_state == S_HALT);
  assign illegal_op  = r_illegal;
  assign instr_count = r_instr_count;

endmodule
